// File: rtl/flash_erase_sequencer_if.sv
// User-side request/status and SPI-driver-side frame signals of the erase sequencer.
// The master modport is the sequencer's view; slave is the user/driver side.
interface flash_erase_sequencer_if;
  logic        op_start;
  logic [23:0] op_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  status;
  logic        spi_start;
  logic [1:0]  spi_cmd;
  logic [7:0]  spi_width;
  logic [31:0] spi_tx;
  logic        spi_done;
  logic [7:0]  spi_rx;

  modport master (
    input  op_start, op_addr, spi_done, spi_rx,
    output spi_start, spi_cmd, spi_width, spi_tx, busy, done, err, status
  );

  modport slave (
    output op_start, op_addr, spi_done, spi_rx,
    input  spi_start, spi_cmd, spi_width, spi_tx, busy, done, err, status
  );
endinterface

// File: rtl/flash_erase_sequencer.sv
// W25Q16 4 KB sector erase: power-up wait, WREN, SE + address, then RDSR polling
// of WIP with a gap between polls and a poll-count timeout. All outputs are registered.
module flash_erase_sequencer #(
  parameter logic [31:0] PWRUP_CYCLES    = 32'd5000,
  parameter logic [15:0] POLL_GAP_CYCLES = 16'd100,
  parameter logic [15:0] POLL_MAX        = 16'd60000
) (
  input logic                     clk,
  input logic                     rst_n,
  flash_erase_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    PWRUP, IDLE, WREN, WREN_W, ERASE, ERASE_W, GAP, POLL, POLL_W, FIN, FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pwr_cnt_q, pwr_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        req_q, req_d;
  logic [23:0] req_addr_q, req_addr_d;
  logic [23:0] addr_q, addr_d;
  logic        spi_start_q, spi_start_d;
  logic [1:0]  spi_cmd_q, spi_cmd_d;
  logic [7:0]  spi_width_q, spi_width_d;
  logic [31:0] spi_tx_q, spi_tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  status_q, status_d;

  logic [23:0] pick_addr;
  logic        gap_last;
  logic        poll_last;

  // Widened compares keep zero-valued parameters from wrapping.
  assign gap_last  = ({1'b0, gap_cnt_q} + 17'd1)  >= {1'b0, POLL_GAP_CYCLES};
  assign poll_last = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_MAX};

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    req_d       = req_q;
    req_addr_d  = req_addr_q;
    addr_d      = addr_q;
    spi_start_d = 1'b0;
    spi_cmd_d   = spi_cmd_q;
    spi_width_d = spi_width_q;
    spi_tx_d    = spi_tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    status_d    = status_q;
    pick_addr   = bus.op_start ? bus.op_addr : req_addr_q;

    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWRUP_CYCLES) state_d = IDLE;
        else pwr_cnt_d = pwr_cnt_q + 32'd1;
        if (bus.op_start) begin
          req_d      = 1'b1;
          req_addr_d = bus.op_addr;
        end
      end
      IDLE: begin
        if (bus.op_start || req_q) begin
          addr_d  = {pick_addr[23:12], 12'h000};
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = WREN;
        end
      end
      WREN: begin
        spi_start_d = 1'b1;
        spi_cmd_d   = 2'b00;
        spi_width_d = 8'd8;
        spi_tx_d    = {8'h06, 24'h000000};
        state_d     = WREN_W;
      end
      WREN_W: if (bus.spi_done) state_d = ERASE;
      ERASE: begin
        spi_start_d = 1'b1;
        spi_cmd_d   = 2'b00;
        spi_width_d = 8'd32;
        spi_tx_d    = {8'h20, addr_q};
        state_d     = ERASE_W;
      end
      ERASE_W: if (bus.spi_done) state_d = GAP;
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = 16'd0;
          state_d   = POLL;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      POLL: begin
        spi_start_d = 1'b1;
        spi_cmd_d   = 2'b01;
        spi_width_d = 8'd8;
        spi_tx_d    = {8'h05, 24'h000000};
        state_d     = POLL_W;
      end
      POLL_W: begin
        if (bus.spi_done) begin
          status_d = bus.spi_rx;
          if (!bus.spi_rx[0]) begin
            state_d = FIN;
          end else if (poll_last) begin
            state_d = FAIL;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            state_d    = GAP;
          end
        end
      end
      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        poll_cnt_d = 16'd0;
        state_d    = IDLE;
      end
      FAIL: begin
        err_d      = 1'b1;
        busy_d     = 1'b0;
        poll_cnt_d = 16'd0;
        state_d    = IDLE;
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= 32'd0;
      gap_cnt_q   <= 16'd0;
      poll_cnt_q  <= 16'd0;
      req_q       <= 1'b0;
      req_addr_q  <= 24'd0;
      addr_q      <= 24'd0;
      spi_start_q <= 1'b0;
      spi_cmd_q   <= 2'b00;
      spi_width_q <= 8'd8;
      spi_tx_q    <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      status_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      req_q       <= req_d;
      req_addr_q  <= req_addr_d;
      addr_q      <= addr_d;
      spi_start_q <= spi_start_d;
      spi_cmd_q   <= spi_cmd_d;
      spi_width_q <= spi_width_d;
      spi_tx_q    <= spi_tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      status_q    <= status_d;
    end
  end

  assign bus.spi_start = spi_start_q;
  assign bus.spi_cmd   = spi_cmd_q;
  assign bus.spi_width = spi_width_q;
  assign bus.spi_tx    = spi_tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_flash_erase_sequencer.sv
// Directed bench: a negedge SPI driver model with fixed 3-cycle frame latency and a
// queue of RDSR replies, plus per-scenario tasks with hand-computed expectations.
module tb_flash_erase_sequencer;
  localparam int PWR  = 30;
  localparam int GAPC = 5;
  localparam int PMAX = 4;
  localparam int LAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  flash_erase_sequencer_if bus();

  flash_erase_sequencer #(
    .PWRUP_CYCLES   (32'd30),
    .POLL_GAP_CYCLES(16'd5),
    .POLL_MAX       (16'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  width;
    logic [31:0] tx;
    int          cyc;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_default = 8'h00;
  int cyc = 0;
  int drv_cnt = 0;
  int last_done_cyc = -10;
  int done_count = 0;
  int err_count = 0;
  int protocol_errs = 0;
  int busy_errs = 0;
  logic drv_active = 1'b0;
  logic drv_read = 1'b0;
  logic prev_busy = 1'b0;
  int tests = 0;
  int failed = 0;
  int rel_cyc = 0;

  // Driver model and pulse monitor, evaluated mid-cycle away from the DUT clock edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    bus.spi_done = 1'b0;
    if (!rst_n) begin
      drv_active = 1'b0;
      drv_cnt    = 0;
      prev_busy  = 1'b0;
      bus.spi_rx = 8'h00;
    end else begin
      if (bus.spi_start) begin
        if (drv_active || cyc <= last_done_cyc + 1) protocol_errs++;
        frames.push_back('{bus.spi_cmd, bus.spi_width, bus.spi_tx, cyc});
        drv_active = 1'b1;
        drv_cnt    = LAT;
        drv_read   = (bus.spi_cmd == 2'b01);
      end else if (drv_active) begin
        drv_cnt--;
        if (drv_cnt == 0) begin
          bus.spi_done  = 1'b1;
          drv_active    = 1'b0;
          last_done_cyc = cyc;
          if (drv_read && rx_q.size() > 0) bus.spi_rx = rx_q.pop_front();
          else if (drv_read) bus.spi_rx = rx_default;
          else bus.spi_rx = 8'h00;
        end
      end
      if (bus.done) done_count++;
      if (bus.err) err_count++;
      if ((bus.done || bus.err) && bus.busy) busy_errs++;
      if (prev_busy && !bus.busy && !bus.done && !bus.err) busy_errs++;
      prev_busy = bus.busy;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_op(input logic [23:0] addr);
    bus.op_addr  = addr;
    bus.op_start = 1'b1;
    step();
    bus.op_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int d0, e0;
    d0 = done_count;
    e0 = err_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_count != d0 || err_count != e0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frames.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.op_start = 1'b0;
    bus.op_addr  = 24'h0;
    #1 rst_n = 1'b0;
    #2;
    tests++; if (bus.spi_start !== 1'b0) begin failed++; $display("[TB] FAIL reset_spi_start got %b want 0", bus.spi_start); end
    tests++; if (bus.spi_cmd !== 2'b00) begin failed++; $display("[TB] FAIL reset_spi_cmd got %b want 00", bus.spi_cmd); end
    tests++; if (bus.spi_width !== 8'd8) begin failed++; $display("[TB] FAIL reset_spi_width got %0d want 8", bus.spi_width); end
    tests++; if (bus.spi_tx !== 32'h0) begin failed++; $display("[TB] FAIL reset_spi_tx got %h want 0", bus.spi_tx); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin failed++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
    tests++; if (bus.status !== 8'h00) begin failed++; $display("[TB] FAIL reset_status got %h want 00", bus.status); end
    step();
    step();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_latched_request();
    bit ok;
    frames.delete();
    rx_q = '{8'h00};
    while (cyc < rel_cyc + 10) step();
    pulse_op(24'h012345);
    wait_end(300, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL latch_end got timeout want done"); end
    tests++;
    if (frames.size() != 3) begin
      failed++; $display("[TB] FAIL latch_frame_count got %0d want 3", frames.size());
    end else begin
      tests++; if (frames[0].cyc - rel_cyc != PWR + 3) begin failed++; $display("[TB] FAIL latch_first_start got %0d want %0d", frames[0].cyc - rel_cyc, PWR + 3); end
      tests++; if (frames[0].tx !== 32'h06000000 || frames[0].width !== 8'd8 || frames[0].cmd !== 2'b00) begin failed++; $display("[TB] FAIL latch_wren got %h/%0d/%b want 06000000/8/00", frames[0].tx, frames[0].width, frames[0].cmd); end
      tests++; if (frames[1].tx !== 32'h20012000 || frames[1].width !== 8'd32 || frames[1].cmd !== 2'b00) begin failed++; $display("[TB] FAIL latch_erase got %h/%0d/%b want 20012000/32/00", frames[1].tx, frames[1].width, frames[1].cmd); end
      tests++; if (frames[2].tx !== 32'h05000000 || frames[2].width !== 8'd8 || frames[2].cmd !== 2'b01) begin failed++; $display("[TB] FAIL latch_rdsr got %h/%0d/%b want 05000000/8/01", frames[2].tx, frames[2].width, frames[2].cmd); end
    end
    tests++; if (done_count != 1) begin failed++; $display("[TB] FAIL latch_done_count got %0d want 1", done_count); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("[TB] FAIL latch_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_erase_polling();
    bit ok;
    int d0, op_cyc, polls, spacing_bad;
    int last_poll;
    frames.delete();
    rx_q = '{8'h03, 8'h03, 8'h03, 8'h00};
    d0 = done_count;
    step();
    op_cyc = cyc;
    pulse_op(24'h3FFABC);
    wait_end(400, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL poll_end got timeout want done"); end
    tests++;
    if (frames.size() != 6) begin
      failed++; $display("[TB] FAIL poll_frame_count got %0d want 6", frames.size());
    end else begin
      tests++; if (frames[0].cyc != op_cyc + 2) begin failed++; $display("[TB] FAIL poll_wren_latency got %0d want %0d", frames[0].cyc - op_cyc, 2); end
      tests++; if (frames[1].tx !== 32'h203FF000) begin failed++; $display("[TB] FAIL poll_erase_tx got %h want 203FF000", frames[1].tx); end
      polls = 0; spacing_bad = 0; last_poll = -1;
      foreach (frames[i]) begin
        if (frames[i].cmd == 2'b01) begin
          polls++;
          if (last_poll >= 0 && frames[i].cyc - last_poll != LAT + GAPC + 2) spacing_bad++;
          last_poll = frames[i].cyc;
        end
      end
      tests++; if (polls != 4) begin failed++; $display("[TB] FAIL poll_count got %0d want 4", polls); end
      tests++; if (spacing_bad != 0) begin failed++; $display("[TB] FAIL poll_spacing got %0d bad gaps want 0 (spacing %0d)", spacing_bad, LAT + GAPC + 2); end
    end
    step();
    tests++; if (done_count - d0 != 1) begin failed++; $display("[TB] FAIL poll_done_count got %0d want 1", done_count - d0); end
    tests++; if (bus.status !== 8'h00) begin failed++; $display("[TB] FAIL poll_status got %h want 00", bus.status); end
    tests++; if (busy_errs != 0) begin failed++; $display("[TB] FAIL poll_busy_with_done got %0d errors want 0", busy_errs); end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0, e0, polls;
    frames.delete();
    rx_q.delete();
    rx_default = 8'h01;
    d0 = done_count;
    e0 = err_count;
    pulse_op(24'h000FFF);
    wait_end(400, ok);
    step();
    polls = 0;
    foreach (frames[i]) if (frames[i].cmd == 2'b01) polls++;
    tests++; if (!ok) begin failed++; $display("[TB] FAIL timeout_end got timeout want err"); end
    tests++; if (polls != PMAX) begin failed++; $display("[TB] FAIL timeout_polls got %0d want %0d", polls, PMAX); end
    tests++; if (err_count - e0 != 1) begin failed++; $display("[TB] FAIL timeout_err_count got %0d want 1", err_count - e0); end
    tests++; if (done_count != d0) begin failed++; $display("[TB] FAIL timeout_no_done got %0d want 0", done_count - d0); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("[TB] FAIL timeout_busy got %b want 0", bus.busy); end
    tests++; if (bus.status !== 8'h01) begin failed++; $display("[TB] FAIL timeout_status got %h want 01", bus.status); end
    rx_default = 8'h00;
    d0 = done_count;
    frames.delete();
    pulse_op(24'h100000);
    wait_end(300, ok);
    tests++; if (!ok || done_count - d0 != 1) begin failed++; $display("[TB] FAIL timeout_next_op got %0d done want 1", done_count - d0); end
    tests++; if (frames.size() < 2 || frames[1].tx !== 32'h20100000) begin failed++; $display("[TB] FAIL timeout_next_erase got %0d frames want erase 20100000", frames.size()); end
  endtask

  task automatic test_ignore_while_busy();
    bit ok;
    int d0, e0;
    frames.delete();
    rx_q = '{8'h01, 8'h00};
    d0 = done_count;
    e0 = err_count;
    pulse_op(24'h0AB000);
    wait_frames(2, 100, ok);
    pulse_op(24'h555555);
    wait_frames(3, 100, ok);
    pulse_op(24'h666666);
    wait_end(300, ok);
    for (int i = 0; i < 60; i++) step();
    tests++; if (!ok) begin failed++; $display("[TB] FAIL ignore_end got timeout want done"); end
    tests++; if (frames.size() != 4) begin failed++; $display("[TB] FAIL ignore_frame_count got %0d want 4", frames.size()); end
    tests++; if (frames.size() < 2 || frames[1].tx !== 32'h200AB000) begin failed++; $display("[TB] FAIL ignore_erase_addr got %0d frames want erase 200AB000", frames.size()); end
    tests++; if (done_count - d0 != 1 || err_count != e0) begin failed++; $display("[TB] FAIL ignore_pulses got done %0d err %0d want 1/0", done_count - d0, err_count - e0); end
    tests++; if (protocol_errs != 0) begin failed++; $display("[TB] FAIL frame_protocol got %0d violations want 0", protocol_errs); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    frames.delete();
    rx_q.delete();
    rx_default = 8'h01;
    pulse_op(24'h200000);
    wait_frames(4, 200, ok);
    step();
    tests++; if (!ok || bus.status !== 8'h01) begin failed++; $display("[TB] FAIL rstmid_prep got status %h want 01 before reset", bus.status); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.spi_start !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin failed++; $display("[TB] FAIL rstmid_flags got busy %b start %b done %b err %b want 0", bus.busy, bus.spi_start, bus.done, bus.err); end
    tests++; if (bus.spi_cmd !== 2'b00 || bus.spi_width !== 8'd8 || bus.spi_tx !== 32'h0) begin failed++; $display("[TB] FAIL rstmid_frame got %b/%0d/%h want 00/8/0", bus.spi_cmd, bus.spi_width, bus.spi_tx); end
    tests++; if (bus.status !== 8'h00) begin failed++; $display("[TB] FAIL rstmid_status got %h want 00", bus.status); end
    step();
    step();
    rst_n = 1'b1;
    rel_cyc = cyc;
    frames.delete();
    for (int i = 0; i < PWR + 40; i++) step();
    tests++; if (frames.size() != 0) begin failed++; $display("[TB] FAIL rstmid_no_frames got %0d want 0", frames.size()); end
    rx_default = 8'h00;
    d0 = done_count;
    pulse_op(24'h1FF123);
    wait_end(300, ok);
    tests++; if (!ok || frames.size() < 2 || frames[1].tx !== 32'h201FF000) begin failed++; $display("[TB] FAIL rstmid_new_op got %0d frames want erase 201FF000 then done", frames.size()); end
    tests++; if (done_count - d0 != 1) begin failed++; $display("[TB] FAIL rstmid_done got %0d want 1", done_count - d0); end
  endtask

  initial begin
    test_reset();
    test_latched_request();
    test_erase_polling();
    test_timeout();
    test_ignore_while_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
